// File: rtl/csa_accumulator_ctrl_if.sv
// Operand stream in / resolved sum out handshake bundle for csa_accumulator_ctrl.
// master drives operands and out_ready; slave is the accumulator.
interface csa_accumulator_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  out_data,
        input  out_count,
        input  out_sat,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output out_data,
        output out_count,
        output out_sat,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/csa_accumulator_ctrl.sv
// Multi-operand mod-2^32 adder: operands fold into a carry-save S/C pair through one
// 3:2 compressor; a single carry-propagate add resolves the pair once per stream.
module csa_accumulator_ctrl #(
    parameter int unsigned CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_accumulator_ctrl_if.slave bus
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [DATA_W-1:0] s_q,         s_d;
    logic [DATA_W-1:0] c_q,         c_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              sat_q,       sat_d;
    logic [DATA_W-1:0] res_q,       res_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_sat_q,   out_sat_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;

    // Majority term shifted left; bit 31 of the majority falls off, which is exact mod 2^32.
    logic [DATA_W-1:0] csa_sum_c;
    logic [DATA_W-1:0] csa_carry_c;

    assign csa_sum_c   = s_q ^ c_q ^ bus.in_data;
    assign csa_carry_c = ((s_q & c_q) | (s_q & bus.in_data) | (c_q & bus.in_data)) << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        res_d       = res_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        unique case (state_q)
            ST_ACC: begin
                if (bus.in_valid) begin
                    s_d = csa_sum_c;
                    c_d = csa_carry_c;
                    // Count saturates at all-ones; the overflow is remembered in sat.
                    if (cnt_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (bus.in_last) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                res_d       = s_q + c_q;
                out_count_d = cnt_q;
                out_sat_d   = sat_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = res_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

endmodule
